// File: rtl/lut_exp_pkg.sv
// Shared types and constants for the LUT-based exponential unit.
// The default table below is only used when LUT_EXP_DEFAULT_TABLE_EN is defined.
package lut_exp_pkg;

  localparam int LUT_IN_W     = 8;
  localparam int LUT_IDX_W    = 4;
  localparam int LUT_OUT_W    = 12;
  localparam int LUT_OUT_FRAC = 8;

  typedef logic [LUT_OUT_W-1:0] entry_t;

  // round(e^k * 256) clamped to 4095, indexed by the two's-complement pattern of k
  localparam entry_t LUT_EXP_DEFAULT_TABLE [16] = '{
    12'd256,  12'd696,  12'd1892, 12'd4095,
    12'd4095, 12'd4095, 12'd4095, 12'd4095,
    12'd0,    12'd0,    12'd1,    12'd2,
    12'd5,    12'd13,   12'd35,   12'd94
  };

  function automatic int calc_fw(input int in_w, input int idx_w);
    return in_w - idx_w;
  endfunction

endpackage

// File: rtl/lut_exp_table.sv
// Exp table register file: one write port, two combinational read ports.
// Reads see the pre-write contents in the cycle of a write (read-before-write).
module lut_exp_table
  import lut_exp_pkg::*;
#(
  parameter int IDX_W    = 4,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr0,
  output logic [OUT_W-1:0] rdata0,
  input  logic [IDX_W-1:0] raddr1,
  output logic [OUT_W-1:0] rdata1
);

  localparam int DEPTH = 1 << IDX_W;

  logic [OUT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
`ifdef LUT_EXP_DEFAULT_TABLE_EN
        mem[k] <= OUT_W'(LUT_EXP_DEFAULT_TABLE[k[3:0]]);
`else
        mem[k] <= OUT_W'(1) << OUT_FRAC;
`endif
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/lut_exp_interp.sv
// Pipelined e^x unit: table lookup plus linear interpolation, 3-stage valid/ready stream.
// Optional LUT_EXP_DEFAULT_TABLE_EN: table resets to the packaged e^k values.
module lut_exp_interp
  import lut_exp_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int IDX_W    = 4,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_scale,
  output logic             out_edge,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [OUT_W-1:0] cfg_data
);

  localparam int FW     = calc_fw(IN_W, IDX_W);
  localparam int PW     = OUT_W + 1 + FW;
  localparam int STAGES = 3;

  if (FW < 1) begin : g_bad_fw
    $error("lut_exp_interp: IN_W must exceed IDX_W");
  end

`ifdef LUT_EXP_DEFAULT_TABLE_EN
  if (IDX_W != 4 || OUT_W != 12 || OUT_FRAC != 8) begin : g_bad_cfg
    $error("lut_exp_interp: default table needs IDX_W=4, OUT_W=12, OUT_FRAC=8");
  end
`endif

  typedef struct packed {
    logic [OUT_W-1:0] ti;
    logic [OUT_W-1:0] tn;
    logic [FW-1:0]    f;
    logic             at_edge;
  } s1_t;

  typedef struct packed {
    logic [OUT_W-1:0] ti;
    logic [PW-1:0]    p;
    logic             at_edge;
  } s2_t;

  logic              en;
  logic [STAGES:1]   vld_pipe;
  logic [IDX_W-1:0]  idx_i, idx_n;
  logic [FW-1:0]     frac;
  logic              at_max;
  logic [OUT_W-1:0]  rd_i, rd_n;
  s1_t               s1;
  s2_t               s2;
  logic signed [PW-1:0] d_c, f_c, p_c;
  logic [OUT_W-1:0]  res_c;

  // whole pipe advances together; bubbles stay in place
  assign en        = out_ready || !out_valid;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  assign idx_i  = in_x[IN_W-1 -: IDX_W];
  assign frac   = in_x[FW-1:0];
  assign at_max = (idx_i == {1'b0, {(IDX_W-1){1'b1}}});
  // -1 wraps to 0 naturally; only the top positive index has no right neighbour
  assign idx_n  = at_max ? idx_i : idx_i + 1'b1;

  lut_exp_table #(
    .IDX_W    (IDX_W),
    .OUT_W    (OUT_W),
    .OUT_FRAC (OUT_FRAC)
  ) u_tbl (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wdata  (cfg_data),
    .raddr0 (idx_i),
    .rdata0 (rd_i),
    .raddr1 (idx_n),
    .rdata1 (rd_n)
  );

  assign d_c = $signed(PW'(s1.tn)) - $signed(PW'(s1.ti));
  assign f_c = $signed(PW'(s1.f));
  assign p_c = d_c * f_c;

  // floor-shift keeps the result inside [T[i],T[n]], so low OUT_W bits are exact
  assign res_c = s2.ti + OUT_W'($signed(s2.p) >>> FW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      s1        <= '0;
      s2        <= '0;
      out_scale <= '0;
      out_edge  <= 1'b0;
    end else if (en) begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], in_valid};
      s1.ti      <= rd_i;
      s1.tn      <= rd_n;
      s1.f       <= frac;
      s1.at_edge <= at_max && (frac != '0);
      s2.ti      <= s1.ti;
      s2.p       <= p_c;
      s2.at_edge <= s1.at_edge;
      out_scale  <= res_c;
      out_edge   <= s2.at_edge;
    end
  end

endmodule

// File: tb/tb_lut_exp_interp.sv
// Directed bench for lut_exp_interp with an expected-result queue scoreboard.
// Works with or without LUT_EXP_DEFAULT_TABLE_EN (the table is loaded over cfg).
module tb_lut_exp_interp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_scale;
  logic        out_edge;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [11:0] cfg_data = '0;

  lut_exp_interp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_scale (out_scale),
    .out_edge  (out_edge),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] scale;
    logic        edg;
    int          cyc;
  } exp_t;

  localparam int DEF [16] = '{256, 696, 1892, 4095, 4095, 4095, 4095, 4095,
                              0, 0, 1, 2, 5, 13, 35, 94};
`ifdef LUT_EXP_DEFAULT_TABLE_EN
  localparam int RST_35 = 4095;
  localparam int RST_10 = 696;
`else
  localparam int RST_35 = 256;
  localparam int RST_10 = 256;
`endif

  exp_t        sb[$];
  exp_t        mon_e;
  int          tm [16];
  int          nchk = 0, nerr = 0, cyc = 0;
  bit          lat_chk = 1'b0;
  logic        hv = 1'b0, he;
  logic [11:0] hs;
  logic [7:0]  xs [8] = '{8'h00, 8'h08, 8'hF8, 8'h7F, 8'h21, 8'hC3, 8'h9A, 8'h35};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference: floor interpolation over the bench's own copy of the table
  function automatic logic [11:0] mscale(input logic [7:0] x);
    int i, n, f, p;
    i = int'(x[7:4]);
    f = int'(x[3:0]);
    n = (i == 7) ? 7 : (i + 1) % 16;
    p = (tm[n] - tm[i]) * f;
    return 12'(tm[i] + (p >>> 4));
  endfunction

  function automatic logic medge(input logic [7:0] x);
    return (x[7:4] == 4'h7) && (x[3:0] != 4'h0);
  endfunction

  task automatic send(input logic [7:0] x, input logic [11:0] es, input logic ee);
    in_valid = 1'b1;
    in_x     = x;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{es, ee, cyc});
        @(posedge clk); #1;
        return;
      end
    end
    nchk++; nerr++;
    $error("FAIL accept_timeout observed=not_accepted expected=accepted x=%0h", x);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    nchk++; nerr++;
    $error("FAIL drain_timeout observed=%0d pending expected=0", sb.size());
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [11:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      hv = 1'b0;
    end else begin
      if (hv) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_scale", 32'(out_scale), 32'(hs));
        check("hold_edge",  32'(out_edge),  32'(he));
      end
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          nchk++; nerr++;
          $error("FAIL unexpected_out observed=%0d expected=none", out_scale);
        end else begin
          mon_e = sb.pop_front();
          check("scale", 32'(out_scale), 32'(mon_e.scale));
          check("edge",  32'(out_edge),  32'(mon_e.edg));
          if (lat_chk) check("latency", 32'(cyc - mon_e.cyc), 32'd3);
        end
      end
      hv = out_valid && !out_ready;
      hs = out_scale;
      he = out_edge;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_scale", 32'(out_scale), 32'd0);
    check("rst_edge",  32'(out_edge),  32'd0);
    rst = 1'b0;
    lat_chk = 1'b1;

    // reset-contents lookup
    send(8'h35, 12'(RST_35), 1'b0);
    drain();

    for (int k = 0; k < 16; k++) begin
      cfg_write(4'(k), 12'(DEF[k]));
      tm[k] = DEF[k];
    end

    // integer points, fractional points incl. -1 -> 0 wrap, top-index edge
    send(8'h00, 12'd256, 1'b0);
    send(8'h10, 12'd696, 1'b0);
    send(8'h08, 12'd476, 1'b0);
    send(8'hF8, 12'd175, 1'b0);
    send(8'h7F, 12'd4095, 1'b1);
    send(8'h70, 12'd4095, 1'b0);
    drain();

    // stream with out_ready pattern 1,0,0,1
    lat_chk = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) send(xs[k], mscale(xs[k]), medge(xs[k]));
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          out_ready = (k % 4 == 0) || (k % 4 == 3);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // write coinciding with accept reads the old entry
    lat_chk = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 12'd1000;
    send(8'h18, 12'd1294, 1'b0);
    cfg_we = 1'b0;
    tm[1] = 1000;
    send(8'h18, 12'd1446, 1'b0);
    idle(1);
    // descending segment: floor toward -inf
    cfg_write(4'd2, 12'd500);
    tm[2] = 500;
    send(8'h1F, 12'd531, 1'b0);
    drain();

    // reset with beats in flight
    lat_chk = 1'b0;
    out_ready = 1'b0;
    send(8'h10, mscale(8'h10), 1'b0);
    send(8'h20, mscale(8'h20), 1'b0);
    idle(3);
    check("stall_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_scale", 32'(out_scale), 32'd0);
    check("midrst_edge",  32'(out_edge),  32'd0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale", 32'(seen), 32'd0);
    @(posedge clk); #1;
    lat_chk = 1'b1;
    send(8'h10, 12'(RST_10), 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/lut_exp_interp.md
Name: lut_exp_interp

Overview:
Parametrised, pipelined exponential unit for the PE datapath.
- Input: signed fixed-point x, split into table index (high bits) and fraction (low bits).
- Output: unsigned fixed-point e^x scale, linearly interpolated between adjacent entries of a runtime-programmable table.
- Valid/ready stream on the datapath side; simple write port for table configuration.

Parameters:
IN_W, 8, input width (two's complement)
IDX_W, 4, index width = top IDX_W bits of x (signed integer part); table depth 2^IDX_W
OUT_W, 12, table entry / output width (unsigned)
OUT_FRAC, 8, output fractional bits (entry value 1<<OUT_FRAC = 1.0)
(derived) FW = IN_W-IDX_W, fraction width; must be >=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input accepted when in_valid && in_ready
in_x  in  IN_W  signed input
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_scale  out  OUT_W  interpolated exp scale
out_edge  out  1  index was max positive with nonzero fraction; no interpolation performed
cfg_we  in  1  table write strobe
cfg_addr  in  IDX_W  table entry (two's-complement index encoding)
cfg_data  in  OUT_W  entry value

Behaviour:
- Decided: one clock, clk; reset rst, asynchronous, active-high.
- Reset: out_valid=0, out_scale=0, out_edge=0, all stage valids 0. Every table entry = 1<<OUT_FRAC, or the default table when the macro is defined.
- in_ready = out_ready || !out_valid (global stall enable `en`). Bubbles are not collapsed.
- Pipeline latency: 3 cycles with out_ready held 1; throughput 1/cycle.
- Index decode: i = in_x[IN_W-1 -: IDX_W]; f = in_x[FW-1:0] (unsigned).
  - Next entry n = i+1 modulo 2^IDX_W, numeric order: -1 -> 0 -> 1.
  - If i is max positive (0111.. pattern), n = i; out_edge = (f != 0).
- S1 (on accept): read T[i], T[n]; latch f and edge.
- S2: d = T[n]-T[i], signed OUT_W+1; p = d*f, signed OUT_W+1+FW.
- S3: out_scale = T[i] + (p >>> FW).
  - Arithmetic shift; truncation toward -inf.
  - Result always lies within [T[i],T[n]], so no clamp is needed. Width OUT_W+1 internal, low OUT_W bits out.
- Output hold: while out_valid && !out_ready, out_scale/out_edge/out_valid are held stable and all stages freeze.
- Table writes:
  - Always accepted, regardless of stall.
  - Take effect the following cycle.
  - S1 read in the same cycle as a write to the same address returns the old value (read-before-write).
  - Beats already past S1 are unaffected.
- Reset mid-operation: all in-flight beats are discarded; table returns to its reset contents.

Optional Feature:
- Macro: LUT_EXP_DEFAULT_TABLE_EN
- Defined: table resets to round(e^k * 2^OUT_FRAC), clamped to 2^OUT_W-1, for k = -2^(IDX_W-1)..2^(IDX_W-1)-1, taken from the package constant.
  - Only valid for IDX_W=4, OUT_W=12, OUT_FRAC=8; other values are an elaboration $error.
  - Entries for k = -8..7: 0,0,1,2,5,13,35,94,256,696,1892,4095,4095,4095,4095,4095.
- Undefined: all entries reset to 1<<OUT_FRAC; software must load the table before use.

Decomposition:
- Package lut_exp_pkg holds:
  - the default-table constant array (indexed by the two's-complement pattern);
  - a typedef for the entry type, logic [OUT_W-1:0];
  - a localparam function computing FW.
- One natural sub-module, lut_exp_table: register file with async reset, one write port, two combinational read ports, read-before-write.
- Decode, multiply and add stay in the top module.

Test Plan:
1. Macro defined, out_ready=1; in_x=0x00 then 0x10 -> out_scale 256 then 696, 3 cycles after each accept, out_edge=0.
2. in_x=0x08 (0.5) -> 256+((696-256)*8>>4) = 476; in_x=0xF8 (-0.5) -> 94+((256-94)*8>>4) = 175 (wrap from index -1 to 0).
3. in_x=0x7F -> out_scale 4095, out_edge=1; in_x=0x70 -> 4095, out_edge=0.
4. Back-to-back stream of 8 beats with out_ready toggling 1,0,0,1… -> every result is delivered in order, exactly once; outputs are stable while stalled; in_ready=0 exactly when out_valid && !out_ready.
5. Write cfg_addr=1, cfg_data=1000 in the same cycle in_x=0x18 is accepted -> result uses the old T[1]=696 (696+((1892-696)*8>>4) = 1294). The next beat 0x18 -> 1000+((1892-1000)*8>>4) = 1446.
6. Macro undefined: reset then in_x=0x35 -> 256. Assert rst with 2 beats in flight -> out_valid drops to 0 immediately, and no stale beat emerges after release.
